mmu_skew_feeder: RTL and testbench
==================================

MMU_SKEW_FEEDER -- requirements
Module: mmu_skew_feeder

Interface
REQ-001 SHALL have parameter N, default 2, meaning systolic array dimension (N>=2).
REQ-002 SHALL have parameter DW, default 8, meaning element width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  load element present.
REQ-006 SHALL have port in_sel  input  1  target buffer: 0=A (activations), 1=B (weights).
REQ-007 SHALL have port in_data  input  DW  load element, row-major order.
REQ-008 SHALL have port in_ready  output  1  element accepted when in_valid & in_ready.
REQ-009 SHALL have port start  input  1  one-cycle request to stream.
REQ-010 SHALL have port busy  output  1  high while STREAM.
REQ-011 SHALL have port done  output  1  one-cycle pulse after last stream cycle.
REQ-012 SHALL have port out_valid  output  1  high on every STREAM output cycle.
REQ-013 SHALL have port a_out  output  N*DW  lane i (bits i*DW+:DW) drives array row i.
REQ-014 SHALL have port b_out  output  N*DW  lane j drives array column j.

Function
REQ-015 SHALL implement FSM IDLE -> STREAM -> DONE -> IDLE; reset state IDLE.
REQ-016 SHALL hold per buffer an N*N element store, write index 0..N*N-1 and full flag.
REQ-017 in_ready SHALL be combinational: state==IDLE & !full[in_sel].
REQ-018 SHALL on accepted write store in_data at index, increment index; at N*N-1 set full, index wraps to 0.
REQ-019 start in IDLE with both full SHALL enter STREAM next cycle; otherwise start SHALL be ignored, no error.
REQ-020 STREAM SHALL last exactly 2N-1 cycles, stream counter t=0..2N-2; first out_valid the cycle after start sampled.
REQ-021 a_out lane i at t SHALL be A[i][t-i] if 0<=t-i<N, else 0.
REQ-022 b_out lane j at t SHALL be B[t-j][j] if 0<=t-j<N, else 0.
REQ-023 a_out, b_out, out_valid, busy, done SHALL be registered; outside STREAM a_out=b_out=0, out_valid=0.
REQ-024 DONE SHALL last one cycle with done=1, clear A full flag/index, and clear B per REQ-030.
REQ-025 start during STREAM or DONE SHALL be ignored; in_valid there SHALL not be accepted.
REQ-026 Writes to a full buffer SHALL be refused (in_ready=0), other buffer unaffected.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, indices 0, full flags 0, all outputs except in_ready 0.
REQ-028 Reset mid-STREAM SHALL abort with no done pulse; store contents need not be cleared.

Configuration
REQ-029 Macro MMU_FEEDER_WEIGHT_REUSE_EN SHALL select weight retention.
REQ-030 With it defined, DONE SHALL keep B full (only A reload needed per pass); a B write while B full SHALL be refused per REQ-026. Without it, DONE SHALL clear B full flag and index.

Structure
REQ-031 Package mmu_pkg SHALL hold the FSM state enum and defaults for N and DW.
REQ-032 Sub-module mmu_feeder_buf (store, index, full flag, skewed read port) SHALL be instantiated twice (A, B).

Verification (N=2, DW=8)
REQ-033 Load A=1,2,3,4, B=5,6,7,8, start -> t0 a=[1,0] b=[5,0]; t1 a=[2,3] b=[7,6]; t2 a=[0,4] b=[0,8]; done next cycle.
REQ-034 Load only A (4 elems), start -> no busy, in_ready stays 1 for in_sel=1, stays 0 for in_sel=0.
REQ-035 Fifth write to A after 4 -> in_ready=0, A contents unchanged on later stream.
REQ-036 Assert rst_n low at t1 of stream -> outputs 0 immediately, no done, in_ready=1 after release.
REQ-037 With MMU_FEEDER_WEIGHT_REUSE_EN: second pass loads A=9,10,11,12 only, start -> t1 a=[10,11] b=[7,6]; without macro same start ignored.
REQ-038 in_valid and start held during STREAM -> no writes accepted, no restart, exactly one done.

Source files
------------

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared definitions for the systolic-array skew feeder.
//   - MMU_N_DEFAULT / MMU_DW_DEFAULT : default array dimension and element width
//   - mmu_state_e                    : feeder FSM state encoding (IDLE/STREAM/DONE)
package mmu_pkg;

    localparam int MMU_N_DEFAULT  = 2;
    localparam int MMU_DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } mmu_state_e;

endpackage

// File: rtl/mmu_feeder_buf.sv
// mmu_feeder_buf: one N x N operand buffer with a skewed read port.
//   Elements are written in row-major order; after N*N writes the buffer
//   reports full and the write index wraps to 0.
//   The read port returns, for stream step rd_t, one element per lane k:
//     TRANSPOSE=0 (activations): lane k = M[k][rd_t-k]
//     TRANSPOSE=1 (weights)    : lane k = M[rd_t-k][k]
//   and 0 when rd_t-k falls outside 0..N-1.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, wr_data  accepted write (caller guarantees !full)
//   clr             clear full flag and write index
//   rd_t            stream step to read
//   full            buffer holds N*N elements
//   rd_lanes        N lanes of DW bits, lane k at bits k*DW +: DW
module mmu_feeder_buf
    import mmu_pkg::*;
#(
    parameter int N         = MMU_N_DEFAULT,
    parameter int DW        = MMU_DW_DEFAULT,
    parameter bit TRANSPOSE = 1'b0,
    parameter int TW        = $clog2(2 * N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [DW-1:0]   wr_data,
    input  logic            clr,
    input  logic [TW-1:0]   rd_t,
    output logic            full,
    output logic [N*DW-1:0] rd_lanes
);

    localparam int AW = $clog2(N * N);

    logic [DW-1:0] mem [N*N];
    logic [AW-1:0] wr_idx;

    // Store contents are deliberately not reset; only index/full are.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            full   <= 1'b0;
        end else if (clr) begin
            wr_idx <= '0;
            full   <= 1'b0;
        end else if (wr_en) begin
            if (wr_idx == AW'(N * N - 1)) begin
                wr_idx <= '0;
                full   <= 1'b1;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        int            d;
        logic [AW-1:0] idx;
        logic [DW-1:0] lane;

        // d is the position along the lane's row (A) or column (B).
        always_comb begin
            d    = int'(rd_t) - k;
            idx  = '0;
            lane = '0;
            if (d >= 0 && d < N) begin
                idx  = TRANSPOSE ? AW'(d * N + k) : AW'(k * N + d);
                lane = mem[idx];
            end
        end

        assign rd_lanes[k*DW +: DW] = lane;
    end

endmodule

// File: rtl/mmu_skew_feeder.sv
// mmu_skew_feeder: loads A (activations) and B (weights) N x N matrices and
// streams them into a systolic array with the diagonal skew the array needs.
//
// Handshake: an element is accepted on a rising edge where in_valid & in_ready;
// in_ready is combinational (IDLE and target buffer not full) and does not
// depend on in_valid. start is a single-cycle request, honoured only in IDLE
// with both buffers full, otherwise silently dropped.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, in_sel, in_data   load element (in_sel 0=A, 1=B), row-major
//   in_ready                    load element accepted this cycle if in_valid
//   start                       request to stream
//   busy, out_valid             high on each of the 2N-1 stream cycles
//   done                        one-cycle pulse after the last stream cycle
//   a_out, b_out                skewed lanes for array rows / columns
//   dbg_state                   current FSM state
//
// Build option: define MMU_FEEDER_WEIGHT_REUSE_EN to keep B loaded across
// passes so only A must be reloaded before the next start.
module mmu_skew_feeder
    import mmu_pkg::*;
#(
    parameter int N  = MMU_N_DEFAULT,
    parameter int DW = MMU_DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_sel,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            out_valid,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output mmu_state_e      dbg_state
);

    localparam int          TW     = $clog2(2 * N);
    localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

    mmu_state_e      state;
    logic [TW-1:0]   t;
    logic [TW-1:0]   rd_t;
    logic            a_full, b_full;
    logic            wr_a, wr_b;
    logic            clr_a, clr_b;
    logic [N*DW-1:0] a_rd, b_rd;

    assign dbg_state = state;

    assign in_ready = (state == ST_IDLE) && !(in_sel ? b_full : a_full);
    assign wr_a     = in_valid && in_ready && !in_sel;
    assign wr_b     = in_valid && in_ready &&  in_sel;

    // Outputs are registered, so the read port looks one step ahead of t.
    assign rd_t = (state == ST_STREAM) ? t + 1'b1 : '0;

    assign clr_a = (state == ST_DONE);
`ifdef MMU_FEEDER_WEIGHT_REUSE_EN
    assign clr_b = 1'b0;
`else
    assign clr_b = (state == ST_DONE);
`endif

    mmu_feeder_buf #(.N(N), .DW(DW), .TRANSPOSE(1'b0), .TW(TW)) u_buf_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_a),
        .wr_data  (in_data),
        .clr      (clr_a),
        .rd_t     (rd_t),
        .full     (a_full),
        .rd_lanes (a_rd)
    );

    mmu_feeder_buf #(.N(N), .DW(DW), .TRANSPOSE(1'b1), .TW(TW)) u_buf_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_b),
        .wr_data  (in_data),
        .clr      (clr_b),
        .rd_t     (rd_t),
        .full     (b_full),
        .rd_lanes (b_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            t         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && a_full && b_full) begin
                        state     <= ST_STREAM;
                        t         <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        a_out     <= a_rd;
                        b_out     <= b_rd;
                    end
                end
                ST_STREAM: begin
                    if (t == T_LAST) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        a_out     <= '0;
                        b_out     <= '0;
                        done      <= 1'b1;
                    end else begin
                        t     <= t + 1'b1;
                        a_out <= a_rd;
                        b_out <= b_rd;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_skew_feeder.sv
// Testbench for mmu_skew_feeder (N=2, DW=8): reset checks, a table of
// known load/stream vectors, hand-written corner sequences and randomized
// loads compared against a matrix-level reference model.
module tb_mmu_skew_feeder;
    import mmu_pkg::*;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int NT = 2 * N - 1;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_sel = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_ready;
    logic            start = 1'b0;
    logic            busy, done, out_valid;
    logic [N*DW-1:0] a_out, b_out;
    mmu_state_e      dbg_state;

    always #5 clk = ~clk;

    mmu_skew_feeder #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .a_out     (a_out),
        .b_out     (b_out),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_q[$];   // {b_out, a_out} per stream step

    logic [DW-1:0] cur_a [N*N];
    logic [DW-1:0] cur_b [N*N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: the array at step t sees row i of A delayed by i and
    // column j of B delayed by j.
    task automatic model_push();
        logic [N*DW-1:0] ea, eb;
        for (int t = 0; t < NT; t++) begin
            ea = '0;
            eb = '0;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    ea[i*DW +: DW] = cur_a[i*N + (t - i)];
                    eb[i*DW +: DW] = cur_b[(t - i)*N + i];
                end
            end
            exp_q.push_back({eb, ea});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_valid = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_elem(input logic sel, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        #1;
        check("in_ready_load", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_a();
        for (int i = 0; i < N*N; i++) write_elem(1'b0, cur_a[i]);
    endtask

    task automatic load_b();
        for (int i = 0; i < N*N; i++) write_elem(1'b1, cur_b[i]);
    endtask

    // Pulse start, then compare each stream step against exp_q and the DONE pulse.
    task automatic stream_check(input string name);
        logic [31:0] e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NT; k++) begin
            check({name, "_valid"}, {30'd0, out_valid, busy}, 32'd3);
            if (exp_q.size() == 0) begin
                check({name, "_exp_q_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({name, "_lanes"}, {b_out, a_out}, e);
            end
            @(negedge clk);
        end
        check({name, "_done"}, {29'd0, done, out_valid, busy}, 32'd4);
        check({name, "_zero_out"}, {b_out, a_out}, 32'd0);
        @(negedge clk);
        check({name, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [2:0][15:0] ea;
        logic [2:0][15:0] eb;
    } vec_t;

    vec_t tbl [2];

    initial begin
        int n_done;
        int na, nb;
        logic sel;

        tbl[0].a  = {8'd4, 8'd3, 8'd2, 8'd1};
        tbl[0].b  = {8'd8, 8'd7, 8'd6, 8'd5};
        tbl[0].ea = {16'h0400, 16'h0302, 16'h0001};
        tbl[0].eb = {16'h0800, 16'h0607, 16'h0005};
        tbl[1].a  = {8'h40, 8'h30, 8'h20, 8'h10};
        tbl[1].b  = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
        tbl[1].ea = {16'h4000, 16'h3020, 16'h0010};
        tbl[1].eb = {16'hA400, 16'hA2A3, 16'h00A1};

        // Reset state
        #1;
        check("rst_outputs", {29'd0, busy, done, out_valid}, 32'd0);
        check("rst_lanes", {b_out, a_out}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        do_reset();

        // Table vectors
        for (int v = 0; v < 2; v++) begin
            do_reset();
            for (int i = 0; i < N*N; i++) begin
                cur_a[i] = tbl[v].a[i];
                cur_b[i] = tbl[v].b[i];
            end
            load_a();
            load_b();
            in_sel = 1'b0; #1;
            check("full_a_ready", {31'd0, in_ready}, 32'd0);
            in_sel = 1'b1; #1;
            check("full_b_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            for (int t = 0; t < NT; t++) exp_q.push_back({tbl[v].eb[t], tbl[v].ea[t]});
            stream_check("tbl");
        end

        // Weight reuse: after the last table pass reload only A
        cur_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        cur_a = '{8'd9, 8'd10, 8'd11, 8'd12};
        load_a();
`ifdef MMU_FEEDER_WEIGHT_REUSE_EN
        model_push();
        stream_check("reuse");
`else
        in_sel = 1'b1; #1;
        check("noreuse_b_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("noreuse_no_busy", {30'd0, busy, out_valid}, 32'd0);
        @(negedge clk);
`endif

        // Only A loaded: start ignored; fifth A write refused
        do_reset();
        cur_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        cur_b = '{8'h55, 8'h66, 8'h77, 8'h88};
        load_a();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("only_a_no_busy", {30'd0, busy, out_valid}, 32'd0);
        in_sel = 1'b1; #1;
        check("only_a_b_ready", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b0; #1;
        check("only_a_a_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk);
        in_valid = 1'b0;
        check("fifth_still_idle", {31'd0, busy}, 32'd0);
        load_b();
        model_push();
        stream_check("fifth_write");

        // Reset in the middle of a stream
        do_reset();
        cur_a = '{8'd1, 8'd2, 8'd3, 8'd4};
        cur_b = '{8'd5, 8'd6, 8'd7, 8'd8};
        load_a();
        load_b();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_t1_lanes", {b_out, a_out}, 32'h0607_0302);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", {29'd0, busy, done, out_valid}, 32'd0);
        check("mid_rst_lanes", {b_out, a_out}, 32'd0);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            n_done += int'(done);
        end
        check("mid_rst_no_done", n_done, 32'd0);
        rst_n = 1'b1;
        in_sel = 1'b0; #1;
        check("mid_rst_ready_a", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1; #1;
        check("mid_rst_ready_b", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // in_valid and start held through a stream
        do_reset();
        load_a();
        load_b();
        model_push();
        start    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'h55;
        n_done   = 0;
        for (int k = 0; k < NT; k++) begin
            @(negedge clk);
            n_done += int'(done);
            check("held_state", {30'd0, dbg_state}, {30'd0, ST_STREAM});
            check("held_ready", {31'd0, in_ready}, 32'd0);
            check("held_lanes", {b_out, a_out}, exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF);
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_done += int'(done);
            @(negedge clk);
        end
        check("held_one_done", n_done, 32'd1);
        check("held_idle", {31'd0, busy}, 32'd0);

        // Randomized interleaved loads against the reference model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < N*N; i++) begin
                cur_a[i] = DW'($urandom_range(0, 255));
                cur_b[i] = DW'($urandom_range(0, 255));
            end
            na = 0;
            nb = 0;
            while (na < N*N || nb < N*N) begin
                if (na == N*N)      sel = 1'b1;
                else if (nb == N*N) sel = 1'b0;
                else                sel = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                if (sel) begin
                    write_elem(1'b1, cur_b[nb]);
                    nb++;
                end else begin
                    write_elem(1'b0, cur_a[na]);
                    na++;
                end
            end
            model_push();
            stream_check("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
